pc_gen: RTL
===========

# pc_gen

Parametrised program-counter generator for the fetch stage; next generation of the single-register PC block. Holds the architectural fetch PC and presents it to instruction memory over a valid/ready handshake. Resolves trap, branch and sequential next-PC with fixed priority, and buffers a redirect that arrives while a fetch request is stalled. Adds stall, halt and misaligned-target handling.

## Interface
- XLEN, 32, PC and address width.
- RESET_VECTOR, 32'h0000_0000, first PC fetched after reset.
- PC_STEP, 4, sequential increment; the only legal values are 4 and 2.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- stall_in  in  1  decode hazard; blocks issue of a new fetch request.
- fetch_ready_in  in  1  imem accepts the request this cycle.
- branch_take_in  in  1  EX-stage branch/jump redirect.
- branch_target_in  in  XLEN  branch target.
- trap_take_in  in  1  trap/exception redirect.
- trap_target_in  in  XLEN  trap vector (mtvec).
- halt_in  in  1  stop fetching.
- pc_out  out  XLEN  fetch address, registered.
- pc_plus_4  out  XLEN  pc_out + PC_STEP, mod 2^XLEN.
- pc_valid  out  1  fetch request valid.
- redirect_pending_out  out  1  a buffered redirect is waiting.
- misaligned_out  out  1  one-cycle pulse: a branch target was misaligned.

## Operation
- States: BOOT, RUN, HALTED.
  - BOOT → RUN unconditionally on the first clock after rst_n deasserts.
  - RUN → HALTED when halt_in = 1 and no request is outstanding (pc_valid = 0, or the handshake completes this cycle).
  - HALTED → RUN only on trap_take_in; PC loads the trap target.
- Handshake: fire = pc_valid & fetch_ready_in.
  - pc_valid = (state == RUN) & (!stall_in | hold).
  - hold is a flop set while pc_valid & !fetch_ready_in, cleared on fire.
  - While hold = 1, pc_out and pc_valid are frozen, regardless of stall_in or redirects.
- Next-PC priority, used when the PC may update (fire, or pc_valid = 0 in RUN):
  1. trap_take_in
  2. pending trap
  3. branch_take_in
  4. pending branch
  5. pc_out + PC_STEP on fire
  6. otherwise hold the current value
- Redirect arriving while hold = 1 is written to the pending buffer:
  - A trap overwrites any pending entry.
  - A branch overwrites only a pending branch.
  - The pending entry is consumed (cleared) when the PC updates from it or from a higher-priority source.
- Stall without hold: pc_valid = 0. A redirect loads the PC directly at the next edge and is not buffered.
- Branch target misaligned (target[0] set for PC_STEP = 2; target[1:0] nonzero for PC_STEP = 4):
  - The target is not loaded; PC loads trap_target_in instead.
  - misaligned_out pulses in the cycle the redirect is taken.
- Trap target low bits (1:0, or bit 0 for PC_STEP = 2) are forced to zero before loading.
- Sequential increment wraps modulo 2^XLEN; no overflow flag.

## Timing
- Reset (async, rst_n = 0):
  - state = BOOT, pc_out = RESET_VECTOR, pc_valid = 0, hold = 0.
  - Pending buffer empty, redirect_pending_out = 0, misaligned_out = 0.
- First request: pc_valid = 1 with pc_out = RESET_VECTOR on the first cycle in RUN, i.e. the second rising edge after deassert.
- Latency:
  - Redirect sampled at edge N → pc_out = target from edge N+1 (no hold).
  - Redirect under hold → pc_out = target one edge after fire.
- Simultaneous trap and branch in the same cycle: trap wins; the branch is discarded and not buffered.
- halt_in together with trap_take_in: trap wins; state stays or returns to RUN.
- rst_n asserted mid-handshake: request dropped immediately (pc_valid = 0 asynchronously), pending buffer cleared.
- redirect_pending_out is registered and asserts the cycle after capture.

## Structure
- Shared package pc_pkg:
  - XLEN default
  - pc_state_e enum {BOOT, RUN, HALTED}
  - redirect_kind_e {NONE, BRANCH, TRAP}
- Sub-module pc_redirect_buf: pending kind and target register with the overwrite/consume rules above.
- pc_gen contains the FSM, hold flop, priority mux and misalign check.

## Test plan
- Reset release, ready always 1: pc_valid rises one cycle after BOOT; pc_out sequence 0x0, 0x4, 0x8; pc_plus_4 = 0x4, 0x8, 0xC.
- Request held (pc_valid = 1, fetch_ready_in = 0 for 3 cycles) at 0x10, branch_take_in to 0x200 in cycle 2:
  - pc_out stays 0x10 until fire.
  - redirect_pending_out = 1.
  - Next pc_out = 0x200; pending cleared.
- Pending branch 0x200 under hold, then trap_take_in with trap_target_in = 0x100: after fire pc_out = 0x100; branch discarded.
- Branch to 0x202 with PC_STEP = 4, trap_target_in = 0x100: misaligned_out pulses one cycle; pc_out = 0x100.
- halt_in in RUN: pc_valid drops after the outstanding fire; pc_out frozen. Then trap_take_in to 0x80 → RUN with pc_out = 0x80, pc_valid = 1.
- PC at 0xFFFF_FFFC, ready = 1: next pc_out = 0x0 (wrap). Then rst_n pulsed low mid-hold: pc_valid = 0 immediately; pc_out = RESET_VECTOR.

Source files
------------

// File: rtl/pc_pkg.sv
// pc_pkg: shared types and defaults for the fetch program-counter generator.
package pc_pkg;
    localparam int DEFAULT_XLEN = 32;
    typedef enum logic [1:0] {BOOT, RUN, HALTED} pc_state_e;
    typedef enum logic [1:0] {NONE, BRANCH, TRAP} redirect_kind_e;
endpackage

// File: rtl/pc_gen_if.sv
// pc_gen_if: fetch request handshake between the PC generator and instruction memory.
interface pc_gen_if #(parameter int XLEN = pc_pkg::DEFAULT_XLEN) ();
    logic [XLEN-1:0] pc_out;
    logic [XLEN-1:0] pc_plus_4;
    logic            pc_valid;
    logic            fetch_ready_in;
    modport master (output pc_out, output pc_plus_4, output pc_valid, input fetch_ready_in);
    modport slave (input pc_out, input pc_plus_4, input pc_valid, output fetch_ready_in);
endinterface

// File: rtl/pc_redirect_buf.sv
// pc_redirect_buf: single-entry buffer for a redirect that arrives while a fetch request is held.
module pc_redirect_buf
    import pc_pkg::*;
#(
    parameter int XLEN = DEFAULT_XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_capture,
    input  logic            i_consume,
    input  logic            i_trap,
    input  logic            i_branch,
    input  logic [XLEN-1:0] i_trap_target,
    input  logic [XLEN-1:0] i_branch_target,
    output redirect_kind_e  o_kind,
    output logic [XLEN-1:0] o_target
);
    redirect_kind_e  r_kind;
    logic [XLEN-1:0] r_target;

    // A trap always wins the slot; a branch may only replace another branch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_kind   <= NONE;
            r_target <= '0;
        end else if (i_capture && i_trap) begin
            r_kind   <= TRAP;
            r_target <= i_trap_target;
        end else if (i_capture && i_branch && r_kind != TRAP) begin
            r_kind   <= BRANCH;
            r_target <= i_branch_target;
        end else if (i_consume) begin
            r_kind   <= NONE;
        end
    end

    assign o_kind   = r_kind;
    assign o_target = r_target;
endmodule

// File: rtl/pc_gen.sv
// pc_gen: fetch PC register with trap/branch/sequential priority, request hold,
// buffered redirects, halt and misaligned-branch handling.
module pc_gen
    import pc_pkg::*;
#(
    parameter int              XLEN         = DEFAULT_XLEN,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              PC_STEP      = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    pc_gen_if.master        fetch,
    input  logic            stall_in,
    input  logic            branch_take_in,
    input  logic [XLEN-1:0] branch_target_in,
    input  logic            trap_take_in,
    input  logic [XLEN-1:0] trap_target_in,
    input  logic            halt_in,
    output logic            redirect_pending_out,
    output logic            misaligned_out
);
    localparam logic [XLEN-1:0] LOW_MASK = XLEN'(PC_STEP - 1);

    pc_state_e       r_state;
    pc_state_e       w_state_nxt;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_pc_nxt;
    logic [XLEN-1:0] w_pc_plus;
    logic [XLEN-1:0] w_trap_tgt;
    logic [XLEN-1:0] w_br_tgt;
    logic [XLEN-1:0] w_pend_tgt;
    redirect_kind_e  w_pend_kind;
    logic            r_hold;
    logic            r_mis;
    logic            w_pc_valid;
    logic            w_fire;
    logic            w_upd;
    logic            w_halt_trap;
    logic            w_br_go;
    logic            w_br_mis;
    logic            w_mis_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= BOOT;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            BOOT:    w_state_nxt = RUN;
            RUN:     w_state_nxt = (!trap_take_in && halt_in && (!w_pc_valid || w_fire)) ? HALTED : RUN;
            HALTED:  w_state_nxt = trap_take_in ? RUN : HALTED;
            default: w_state_nxt = BOOT;
        endcase
    end

    always_comb begin
        w_pc_valid = (r_state == RUN) && (!stall_in || r_hold);
    end

    assign w_fire      = w_pc_valid && fetch.fetch_ready_in;
    assign w_upd       = (r_state == RUN) && (w_fire || !w_pc_valid);
    assign w_halt_trap = (r_state == HALTED) && trap_take_in;
    assign w_pc_plus   = r_pc + XLEN'(PC_STEP);
    assign w_trap_tgt  = trap_target_in & ~LOW_MASK;
    assign w_br_go     = branch_take_in || (w_pend_kind == BRANCH);
    assign w_br_tgt    = branch_take_in ? branch_target_in : w_pend_tgt;
    assign w_br_mis    = |(w_br_tgt & LOW_MASK);

    // A misaligned branch is turned into a trap to the current trap vector.
    assign w_pc_nxt = (trap_take_in && (w_upd || w_halt_trap)) ? w_trap_tgt :
                      !w_upd                                    ? r_pc       :
                      (w_pend_kind == TRAP)                     ? w_pend_tgt :
                      w_br_go                                   ? (w_br_mis ? w_trap_tgt : w_br_tgt) :
                      w_fire                                    ? w_pc_plus  : r_pc;
    assign w_mis_nxt = w_upd && !trap_take_in && (w_pend_kind != TRAP) && w_br_go && w_br_mis;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc   <= RESET_VECTOR;
            r_hold <= 1'b0;
            r_mis  <= 1'b0;
        end else begin
            r_pc   <= w_pc_nxt;
            r_hold <= w_pc_valid && !fetch.fetch_ready_in;
            r_mis  <= w_mis_nxt;
        end
    end

    pc_redirect_buf #(.XLEN(XLEN)) u_buf (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_capture       (r_hold && !fetch.fetch_ready_in),
        .i_consume       (w_upd || w_halt_trap),
        .i_trap          (trap_take_in),
        .i_branch        (branch_take_in),
        .i_trap_target   (w_trap_tgt),
        .i_branch_target (branch_target_in),
        .o_kind          (w_pend_kind),
        .o_target        (w_pend_tgt)
    );

    assign fetch.pc_out          = r_pc;
    assign fetch.pc_plus_4       = w_pc_plus;
    assign fetch.pc_valid        = w_pc_valid;
    assign redirect_pending_out  = (w_pend_kind != NONE);
    assign misaligned_out        = r_mis;
endmodule
